// File: rtl/uart_regmap_pkg.sv
// Shared definitions for the UART byte regmap protocol, used by both the host-side
// initiator and the target-side interface.
package uart_regmap_pkg;

    localparam int unsigned CMD_READ_BIT = 7;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StLen,
        StWdata,
        StEcho,
        StRdata,
        StGap
    } regmap_state_e;

    // Command byte is {rw, slave_id}; the target echoes it back on reads.
    function automatic logic [7:0] cmd_byte(input logic rw, input logic [6:0] slave_id);
        logic [7:0] b;
        b = {1'b0, slave_id};
        b[CMD_READ_BIT] = rw;
        return b;
    endfunction

endpackage

// File: rtl/uart_regmap_master_uart_tx_pacer.sv
// Byte pacing towards a uart_tx: registered trigger/data plus a short holdoff so a
// busy flag that rises a cycle or two after the trigger is never missed.
module uart_tx_pacer (
    input  logic       clk,
    input  logic       rst_sync,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       tx_bsy,
    output logic       ready,
    output logic       tx_trig,
    output logic [7:0] send_data
);

    logic [1:0] holdoff_q;
    logic       trig_q;
    logic [7:0] data_q;

    assign ready     = !tx_bsy && (holdoff_q == 2'd0);
    assign tx_trig   = trig_q;
    assign send_data = data_q;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            holdoff_q <= 2'd0;
            trig_q    <= 1'b0;
            data_q    <= 8'h00;
        end else if (load && ready) begin
            holdoff_q <= 2'd2;
            trig_q    <= 1'b1;
            data_q    <= load_data;
        end else begin
            trig_q <= 1'b0;
            if (holdoff_q != 2'd0) begin
                holdoff_q <= holdoff_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_regmap_master.sv
// Host-side initiator for the UART byte regmap protocol: serialises read/write requests
// towards a uart_tx and collects the echo and read data from a uart_rx.
module uart_regmap_master
    import uart_regmap_pkg::*;
#(
    parameter int unsigned NUM_ADDR_BYTES = 2,
    parameter int unsigned GAP_CYCLES     = 512,
    parameter int unsigned RSP_TIMEOUT    = 65535
) (
    input  logic                        clk,
    input  logic                        rst_sync,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_read,
    input  logic [6:0]                  req_slave_id,
    input  logic [8*NUM_ADDR_BYTES-1:0] req_addr,
    input  logic [7:0]                  req_len,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_data_valid,
    output logic                        wr_data_ready,
    output logic [7:0]                  rd_data,
    output logic                        rd_data_valid,
    output logic                        done,
    output logic                        error,
    output logic                        tx_trig,
    output logic [7:0]                  send_data,
    input  logic                        tx_bsy,
    input  logic                        rx_data_valid,
    input  logic [7:0]                  rx_data_out
);

    localparam int unsigned AW    = 8 * NUM_ADDR_BYTES;
    localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    regmap_state_e state_q, state_d;
    logic [8:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             err_q, err_d;
    logic             read_q, read_d;
    logic [6:0]       slave_q, slave_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [7:0]       len_q, len_d;
    logic             rd_valid_q, rd_valid_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic       pace_load;
    logic [7:0] pace_data;
    logic       pace_ready;
    logic [8:0] len_n;
    logic       last_data;
    logic       tmo_hit;

    uart_tx_pacer u_pacer (
        .clk       (clk),
        .rst_sync  (rst_sync),
        .load      (pace_load),
        .load_data (pace_data),
        .tx_bsy    (tx_bsy),
        .ready     (pace_ready),
        .tx_trig   (tx_trig),
        .send_data (send_data)
    );

    // A length byte of zero means a full 256-byte burst.
    assign len_n     = (len_q == 8'h00) ? 9'd256 : {1'b0, len_q};
    assign last_data = (cnt_q == len_n - 9'd1);
    assign tmo_hit   = (tmo_q == TMO_W'(RSP_TIMEOUT));

    assign req_ready     = (state_q == StIdle);
    assign wr_data_ready = (state_q == StWdata) && pace_ready;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign done          = done_q;
    assign error         = error_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        err_d      = err_q;
        read_d     = read_q;
        slave_d    = slave_q;
        addr_d     = addr_q;
        len_d      = len_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        pace_load  = 1'b0;
        pace_data  = 8'h00;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    read_d  = req_read;
                    slave_d = req_slave_id;
                    addr_d  = req_addr;
                    len_d   = req_len;
                    err_d   = 1'b0;
                    cnt_d   = 9'd0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (pace_ready) begin
                    pace_load = 1'b1;
                    pace_data = cmd_byte(read_q, slave_q);
                    cnt_d     = 9'd0;
                    state_d   = StAddr;
                end
            end
            StAddr: begin
                // Address is kept as a shift register so the MSB byte is always on top.
                if (pace_ready) begin
                    pace_load = 1'b1;
                    pace_data = addr_q[AW-1 -: 8];
                    addr_d    = addr_q << 8;
                    if (cnt_q == 9'(NUM_ADDR_BYTES - 1)) begin
                        cnt_d   = 9'd0;
                        state_d = read_q ? StLen : StWdata;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            StLen: begin
                if (pace_ready) begin
                    pace_load = 1'b1;
                    pace_data = len_q;
                    tmo_d     = '0;
                    state_d   = StEcho;
                end
            end
            StWdata: begin
                if (wr_data_valid && pace_ready) begin
                    pace_load = 1'b1;
                    pace_data = wr_data;
                    if (last_data) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end
            end
            StEcho: begin
                if (rx_data_valid) begin
                    tmo_d = '0;
                    if (rx_data_out == cmd_byte(1'b1, slave_q)) begin
                        cnt_d   = 9'd0;
                        state_d = StRdata;
                    end else begin
                        err_d   = 1'b1;
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StRdata: begin
                if (rx_data_valid) begin
                    tmo_d      = '0;
                    rd_valid_d = 1'b1;
                    rd_data_d  = rx_data_out;
                    if (last_data) begin
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            StGap: begin
                // The gap only starts once the last byte has actually left the transmitter.
                if (!pace_ready) begin
                    gap_d = '0;
                end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    done_d  = 1'b1;
                    error_d = err_q;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= StIdle;
            cnt_q      <= 9'd0;
            tmo_q      <= '0;
            gap_q      <= '0;
            err_q      <= 1'b0;
            read_q     <= 1'b0;
            slave_q    <= 7'd0;
            addr_q     <= '0;
            len_q      <= 8'h00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            read_q     <= read_d;
            slave_q    <= slave_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_uart_regmap_master.sv
// Directed bench for uart_regmap_master with a behavioural uart_tx busy model and
// hand-driven rx bytes standing in for the remote target.
module tb_uart_regmap_master;

    localparam int unsigned NB      = 2;
    localparam int unsigned GAP     = 8;
    localparam int unsigned TMO     = 100;
    localparam int          TX_BUSY = 5;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic [6:0]  req_slave_id;
    logic [15:0] req_addr;
    logic [7:0]  req_len;
    logic [7:0]  wr_data;
    logic        wr_data_valid;
    logic        wr_data_ready;
    logic [7:0]  rd_data;
    logic        rd_data_valid;
    logic        done;
    logic        error;
    logic        tx_trig;
    logic [7:0]  send_data;
    logic        tx_bsy = 1'b0;
    logic        rx_data_valid;
    logic [7:0]  rx_data_out;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] wr_log[$];
    logic [7:0] wr_src[$];
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         viol     = 0;
    int         bsy_cnt  = 0;
    logic [7:0] sd_prev  = 8'h00;
    logic       rst_prev = 1'b1;

    uart_regmap_master #(
        .NUM_ADDR_BYTES (NB),
        .GAP_CYCLES     (GAP),
        .RSP_TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .rst_sync      (rst_sync),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_read      (req_read),
        .req_slave_id  (req_slave_id),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .done          (done),
        .error         (error),
        .tx_trig       (tx_trig),
        .send_data     (send_data),
        .tx_bsy        (tx_bsy),
        .rx_data_valid (rx_data_valid),
        .rx_data_out   (rx_data_out)
    );

    always #5 clk = ~clk;

    // uart_tx stand-in: busy rises the edge after a trigger and stays up TX_BUSY cycles.
    always @(posedge clk) begin
        if (tx_trig === 1'b1) begin
            tx_log.push_back(send_data);
            tx_bsy  <= 1'b1;
            bsy_cnt <= TX_BUSY;
        end else if (bsy_cnt != 0) begin
            bsy_cnt <= bsy_cnt - 1;
            if (bsy_cnt == 1) tx_bsy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rd_data_valid === 1'b1) rd_log.push_back(rd_data);
        if (wr_data_valid === 1'b1 && wr_data_ready === 1'b1) wr_log.push_back(wr_data);
        if (done === 1'b1) done_cnt++;
        if (!rst_sync && !rst_prev) begin
            if (tx_trig === 1'b1 && tx_bsy) viol++;
            if (tx_trig !== 1'b1 && send_data !== sd_prev) viol++;
        end
        sd_prev  = send_data;
        rst_prev = rst_sync;
    end

    function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        return (a.size() == b.size()) ? -1 : n;
    endfunction

    function automatic logic [7:0] wdat(input int i);
        return 8'((i * 7 + 3) ^ 8'h3C);
    endfunction

    task automatic do_request(input logic rd, input logic [6:0] sid, input logic [15:0] addr,
                              input logic [7:0] len, output logic rdy0, output logic rdy1,
                              output logic trig1, output logic trig2, output logic [7:0] sd2);
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; req_slave_id = sid; req_addr = addr; req_len = len;
        rdy0 = req_ready;
        @(negedge clk);
        // Scramble the request fields so only the latched copy can be used.
        req_valid = 1'b0; req_read = ~rd; req_slave_id = 7'h7F; req_addr = 16'hDEAD;
        req_len = 8'hEE;
        rdy1 = req_ready; trig1 = tx_trig;
        @(negedge clk);
        trig2 = tx_trig; sd2 = send_data;
    endtask

    task automatic stream_write(input bit rnd, output bit ok);
        int idx = 0;
        int guard = 0;
        while (idx < wr_src.size() && guard < 20000) begin
            @(negedge clk);
            guard++;
            wr_data_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            wr_data = wr_src[idx];
            if (wr_data_valid && wr_data_ready) idx++;
        end
        @(negedge clk);
        wr_data_valid = 1'b0;
        ok = (idx == wr_src.size());
    endtask

    task automatic wait_done(input int budget, output bit got, output logic err,
                             output int idle_run, output int cycles);
        got = 0; err = 1'b0; idle_run = 0; cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1) begin
                got = 1; err = error;
            end else if (tx_bsy) idle_run = 0;
            else idle_run++;
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        int guard = 0;
        while (tx_log.size() < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        ok = (tx_log.size() >= n);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data_valid = 1'b1; rx_data_out = b;
        @(negedge clk);
        rx_data_valid = 1'b0; rx_data_out = 8'h00;
    endtask

    task automatic clear_logs();
        tx_log.delete(); rd_log.delete(); wr_log.delete();
    endtask

    task automatic test_reset();
        rst_sync = 1'b1;
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || tx_trig !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b trig=%b done=%b error=%b, want 1 0 0 0",
                     req_ready, tx_trig, done, error);
        end
        checks++;
        if (wr_data_ready !== 1'b0 || rd_data_valid !== 1'b0 || send_data !== 8'h00
            || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: wr_rdy=%b rd_v=%b send=%h rd=%h, want 0 0 00 00",
                     wr_data_ready, rd_data_valid, send_data, rd_data);
        end
    endtask

    task automatic test_write();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        bit ok, got;
        int idle, cyc, d;
        clear_logs();
        wr_src = '{8'hA5, 8'h5A, 8'hFF};
        do_request(1'b0, 7'd1, 16'h0010, 8'd3, r0, r1, t1, t2, sd);
        checks++;
        if (r0 !== 1'b1 || r1 !== 1'b0) begin
            errors++;
            $display("FAIL write_ready: before=%b after=%b, want 1 0", r0, r1);
        end
        checks++;
        if (t1 !== 1'b0 || t2 !== 1'b1 || sd !== 8'h01) begin
            errors++;
            $display("FAIL write_latency: trig c1=%b c2=%b data=%h, want 0 1 01", t1, t2, sd);
        end
        stream_write(1'b0, ok);
        wait_done(400, got, err, idle, cyc);
        checks++;
        if (!ok || !got || err !== 1'b0) begin
            errors++;
            $display("FAIL write_done: stream=%0d done=%0d error=%b, want 1 1 0", ok, got, err);
        end
        checks++;
        if (idle != GAP) begin
            errors++;
            $display("FAIL write_gap: idle cycles before done=%0d, want %0d", idle, GAP);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: done=%b one cycle later, want 0", done);
        end
        exp_q = '{8'h01, 8'h00, 8'h10, 8'hA5, 8'h5A, 8'hFF};
        d = first_diff(tx_log, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL write_frame: %0d bytes, byte %0d got %h want %h, want %0d bytes",
                     tx_log.size(), d, tx_log[d], exp_q[d], exp_q.size());
        end
    endtask

    task automatic test_read();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        logic [7:0] data[3];
        bit ok, got;
        int idle, cyc, d;
        clear_logs();
        data = '{8'hA5, 8'h5A, 8'hFF};
        do_request(1'b1, 7'd1, 16'h0010, 8'd3, r0, r1, t1, t2, sd);
        checks++;
        if (t1 !== 1'b0 || t2 !== 1'b1 || sd !== 8'h81) begin
            errors++;
            $display("FAIL read_latency: trig c1=%b c2=%b data=%h, want 0 1 81", t1, t2, sd);
        end
        wait_tx(4, ok);
        repeat (20) @(negedge clk);
        send_rx(8'h81);
        checks++;
        if (rd_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_echo_quiet: rd_data_valid=%b after echo, want 0", rd_data_valid);
        end
        // Spacing adds up past the timeout, so it only works if each byte restarts it.
        for (int i = 0; i < 3; i++) begin
            repeat (60) @(negedge clk);
            send_rx(data[i]);
            checks++;
            if (rd_data_valid !== 1'b1 || rd_data !== data[i]) begin
                errors++;
                $display("FAIL read_byte%0d: valid=%b data=%h, want 1 %h",
                         i, rd_data_valid, rd_data, data[i]);
            end
        end
        wait_done(200, got, err, idle, cyc);
        checks++;
        if (!ok || !got || err !== 1'b0 || rd_log.size() != 3) begin
            errors++;
            $display("FAIL read_done: tx_ok=%0d done=%0d error=%b rd_count=%0d, want 1 1 0 3",
                     ok, got, err, rd_log.size());
        end
        exp_q = '{8'h81, 8'h00, 8'h10, 8'h03};
        d = first_diff(tx_log, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL read_frame: %0d bytes, byte %0d got %h want %h, want %0d bytes",
                     tx_log.size(), d, tx_log[d], exp_q[d], exp_q.size());
        end
    endtask

    task automatic test_echo_mismatch();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        bit ok, got;
        int idle, cyc;
        clear_logs();
        do_request(1'b1, 7'd5, 16'h0020, 8'd2, r0, r1, t1, t2, sd);
        wait_tx(4, ok);
        send_rx(8'h82);
        send_rx(8'h11);
        send_rx(8'h22);
        wait_done(200, got, err, idle, cyc);
        checks++;
        if (!ok || !got || err !== 1'b1 || rd_log.size() != 0) begin
            errors++;
            $display("FAIL echo_mismatch: tx_ok=%0d done=%0d error=%b rd_count=%0d, want 1 1 1 0",
                     ok, got, err, rd_log.size());
        end
    endtask

    task automatic test_timeout();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        bit ok, got;
        int idle, cyc, d;
        clear_logs();
        do_request(1'b1, 7'd3, 16'h0004, 8'd1, r0, r1, t1, t2, sd);
        wait_done(2000, got, err, idle, cyc);
        checks++;
        if (!got || err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done=%0d error=%b, want 1 1", got, err);
        end
        checks++;
        if (cyc <= TMO) begin
            errors++;
            $display("FAIL timeout_early: done after %0d cycles, want more than %0d", cyc, TMO);
        end
        clear_logs();
        wr_src = '{8'h77};
        do_request(1'b0, 7'd3, 16'h0001, 8'd1, r0, r1, t1, t2, sd);
        stream_write(1'b0, ok);
        wait_done(400, got, err, idle, cyc);
        exp_q = '{8'h03, 8'h00, 8'h01, 8'h77};
        d = first_diff(tx_log, exp_q);
        checks++;
        if (r0 !== 1'b1 || !ok || !got || err !== 1'b0 || d >= 0) begin
            errors++;
            $display("FAIL timeout_recover: ready=%b stream=%0d done=%0d error=%b diff_at=%0d, want 1 1 1 0 -1",
                     r0, ok, got, err, d);
        end
    endtask

    task automatic test_len0_write();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        bit ok, got;
        int idle, cyc, d;
        clear_logs();
        wr_src.delete();
        for (int i = 0; i < 256; i++) wr_src.push_back(wdat(i));
        do_request(1'b0, 7'h12, 16'h0200, 8'd0, r0, r1, t1, t2, sd);
        stream_write(1'b1, ok);
        wait_done(400, got, err, idle, cyc);
        checks++;
        if (!ok || !got || err !== 1'b0 || wr_log.size() != 256) begin
            errors++;
            $display("FAIL len0_done: stream=%0d done=%0d error=%b handshakes=%0d, want 1 1 0 256",
                     ok, got, err, wr_log.size());
        end
        d = first_diff(wr_log, wr_src);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL len0_handshake: byte %0d got %h want %h", d, wr_log[d], wr_src[d]);
        end
        exp_q = '{8'h12, 8'h02, 8'h00};
        for (int i = 0; i < 256; i++) exp_q.push_back(wdat(i));
        d = first_diff(tx_log, exp_q);
        checks++;
        if (d >= 0) begin
            errors++;
            $display("FAIL len0_frame: %0d bytes, byte %0d got %h want %h, want %0d bytes",
                     tx_log.size(), d, tx_log[d], exp_q[d], exp_q.size());
        end
    endtask

    task automatic test_reset_mid_addr();
        logic r0, r1, t1, t2, err;
        logic [7:0] sd;
        bit ok, got;
        int idle, cyc, d, dc;
        clear_logs();
        do_request(1'b0, 7'd2, 16'h1234, 8'd2, r0, r1, t1, t2, sd);
        @(negedge clk);
        rst_sync = 1'b1;
        dc = done_cnt;
        @(negedge clk);
        checks++;
        if (tx_trig !== 1'b0 || req_ready !== 1'b1 || wr_data_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: trig=%b ready=%b wr_rdy=%b, want 0 1 0",
                     tx_trig, req_ready, wr_data_ready);
        end
        rst_sync = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (done_cnt != dc || tx_log.size() != 1) begin
            errors++;
            $display("FAIL midreset_abort: done pulses=%0d tx bytes=%0d, want 0 1",
                     done_cnt - dc, tx_log.size());
        end
        clear_logs();
        wr_src = '{8'h11, 8'h22};
        do_request(1'b0, 7'd2, 16'h1234, 8'd2, r0, r1, t1, t2, sd);
        stream_write(1'b0, ok);
        wait_done(400, got, err, idle, cyc);
        exp_q = '{8'h02, 8'h12, 8'h34, 8'h11, 8'h22};
        d = first_diff(tx_log, exp_q);
        checks++;
        if (!ok || !got || err !== 1'b0 || d >= 0) begin
            errors++;
            $display("FAIL midreset_followup: stream=%0d done=%0d error=%b diff_at=%0d, want 1 1 0 -1",
                     ok, got, err, d);
        end
    endtask

    task automatic test_tx_protocol();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL tx_protocol: %0d trigger/data violations, want 0", viol);
        end
    endtask

    initial begin
        rst_sync = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_slave_id = 7'd0;
        req_addr = 16'h0000; req_len = 8'h00; wr_data = 8'h00; wr_data_valid = 1'b0;
        rx_data_valid = 1'b0; rx_data_out = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_echo_mismatch();
        test_timeout();
        test_len0_write();
        test_reset_mid_addr();
        test_tx_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
